// File: rtl/dispatch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_scheduler
// Brief    : Single-entry issue stage steering held instructions to ALU/MEM,
//            with an optional busy-register scoreboard (DISPATCH_SCOREBOARD_EN).
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_scheduler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid_in,
  input  logic [75:0]      instr_in,
  output logic             instr_ready_out,
  output logic             alu_valid_out,
  input  logic             alu_ready_in,
  output logic             mem_valid_out,
  input  logic             mem_ready_in,
  output logic [75:0]      issue_instr_out,
  input  logic             wb_valid_in,
  input  logic [4:0]       wb_dest_in,
  input  logic             flush_in,
  output logic             stall_out,
  output logic [CNT_W-1:0] issued_count_out
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [75:0]      r_hold;
  logic [CNT_W-1:0] r_count;

  logic [4:0] w_src1;
  logic [4:0] w_src2;
  logic [4:0] w_dest;
  logic       w_has_addr;
  logic       w_stall_bit;
  logic       w_unit_ready;
  logic       w_issue_fire;
  logic       w_hazard;

  assign w_src1      = r_hold[71:67];
  assign w_src2      = r_hold[66:62];
  assign w_dest      = r_hold[59:55];
  assign w_has_addr  = r_hold[50];
  assign w_stall_bit = r_hold[0];

  assign w_unit_ready = w_has_addr ? mem_ready_in : alu_ready_in;
  // A flush in the handshake cycle cancels the issue entirely.
  assign w_issue_fire = (r_state == S_ISSUE) && w_unit_ready && !flush_in;

`ifdef DISPATCH_SCOREBOARD_EN
  logic [31:1] r_busy;
  logic [31:0] w_busy;

  assign w_busy   = {r_busy, 1'b0};
  assign w_hazard = w_busy[w_src1] | w_busy[w_src2] | w_busy[w_dest];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_issue_fire && (w_dest == 5'(i)))
          r_busy[i] <= 1'b1;
        else if (wb_valid_in && (wb_dest_in == 5'(i)))
          r_busy[i] <= 1'b0;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{wb_valid_in, wb_dest_in};
  assign w_hazard = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    instr_ready_out = 1'b0;
    alu_valid_out   = 1'b0;
    mem_valid_out   = 1'b0;
    stall_out       = 1'b0;
    case (r_state)
      S_EMPTY: begin
        // Refuse the head while flushing so a popped entry is never lost.
        instr_ready_out = !flush_in;
        if (instr_valid_in) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_stall_bit)   w_state_nxt = S_EMPTY;
        else if (w_hazard) stall_out   = 1'b1;
        else               w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mem_valid_out = w_has_addr;
        alu_valid_out = !w_has_addr;
        stall_out     = !w_unit_ready;
        if (w_unit_ready) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    if (flush_in) w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_hold <= '0;
    else if (w_state_nxt == S_EMPTY)
      r_hold <= '0;
    else if (r_state == S_EMPTY)
      r_hold <= instr_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (w_issue_fire && (r_count != {CNT_W{1'b1}}))
      r_count <= r_count + 1'b1;
  end

  assign issue_instr_out  = (r_state == S_EMPTY) ? '0 : r_hold;
  assign issued_count_out = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispatch_scheduler
// Brief    : Directed self-checking bench for dispatch_scheduler (CNT_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dispatch_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid_in;
  logic [75:0] instr_in;
  logic        instr_ready_out;
  logic        alu_valid_out;
  logic        alu_ready_in;
  logic        mem_valid_out;
  logic        mem_ready_in;
  logic [75:0] issue_instr_out;
  logic        wb_valid_in;
  logic [4:0]  wb_dest_in;
  logic        flush_in;
  logic        stall_out;
  logic [3:0]  issued_count_out;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  dispatch_scheduler #(.CNT_W(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_valid_in   (instr_valid_in),
    .instr_in         (instr_in),
    .instr_ready_out  (instr_ready_out),
    .alu_valid_out    (alu_valid_out),
    .alu_ready_in     (alu_ready_in),
    .mem_valid_out    (mem_valid_out),
    .mem_ready_in     (mem_ready_in),
    .issue_instr_out  (issue_instr_out),
    .wb_valid_in      (wb_valid_in),
    .wb_dest_in       (wb_dest_in),
    .flush_in         (flush_in),
    .stall_out        (stall_out),
    .issued_count_out (issued_count_out)
  );

  function automatic logic [75:0] mk(input logic has_addr, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [4:0] d,
                                     input logic stall_b);
    logic [75:0] r;
    r        = '0;
    r[75:72] = 4'h5;
    r[71:67] = s1;
    r[66:62] = s2;
    r[61:60] = 2'b10;
    r[59:55] = d;
    r[54:51] = 4'hA;
    r[50]    = has_addr;
    r[49:2]  = 48'h1234_5678_9ABC;
    r[1]     = 1'b1;
    r[0]     = stall_b;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [75:0] ins);
    instr_valid_in = 1'b1;
    instr_in       = ins;
    step();
    instr_valid_in = 1'b0;
    instr_in       = '0;
    #1;
  endtask

  task automatic handshake_alu();
    alu_ready_in = 1'b1;
    step();
    alu_ready_in = 1'b0;
    #1;
  endtask

  initial begin
    logic [75:0] i1, i2, i3, i4, i5, i6, i8, i9;
    rst_n = 1'b0; instr_valid_in = 1'b0; instr_in = '0;
    alu_ready_in = 1'b0; mem_ready_in = 1'b0;
    wb_valid_in = 1'b0; wb_dest_in = '0; flush_in = 1'b0;
    #3;
    chk("rst_ready", 76'(instr_ready_out), 76'd1);
    chk("rst_alu",   76'(alu_valid_out),   76'd0);
    chk("rst_mem",   76'(mem_valid_out),   76'd0);
    chk("rst_stall", 76'(stall_out),       76'd0);
    chk("rst_instr", issue_instr_out,      76'd0);
    chk("rst_cnt",   76'(issued_count_out), 76'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    step();

    // Basic ALU issue, destination 3
    i1 = mk(1'b0, 5'd1, 5'd2, 5'd3, 1'b0);
    send(i1);
    chk("hold_ready", 76'(instr_ready_out), 76'd0);
    chk("hold_stall", 76'(stall_out),       76'd0);
    chk("hold_alu",   76'(alu_valid_out),   76'd0);
    step();
    chk("i1_alu",   76'(alu_valid_out), 76'd1);
    chk("i1_mem",   76'(mem_valid_out), 76'd0);
    chk("i1_instr", issue_instr_out,    i1);
    chk("i1_stall_wait", 76'(stall_out), 76'd1);
    handshake_alu();
    chk("i1_cnt",   76'(issued_count_out), 76'd1);
    chk("i1_ready", 76'(instr_ready_out),  76'd1);
    chk("i1_empty_instr", issue_instr_out, 76'd0);

    // RAW hazard on register 3, released by writeback
    i2 = mk(1'b0, 5'd3, 5'd0, 5'd4, 1'b0);
    send(i2);
`ifdef DISPATCH_SCOREBOARD_EN
    chk("haz_stall0", 76'(stall_out), 76'd1);
    step();
    chk("haz_stall1", 76'(stall_out), 76'd1);
    chk("haz_alu",    76'(alu_valid_out), 76'd0);
    wb_valid_in = 1'b1; wb_dest_in = 5'd3;
    step();
    wb_valid_in = 1'b0; wb_dest_in = '0;
    #1;
    chk("haz_clr_stall", 76'(stall_out), 76'd0);
    chk("haz_clr_alu",   76'(alu_valid_out), 76'd0);
    step();
`else
    chk("nohaz_stall", 76'(stall_out), 76'd0);
    step();
`endif
    chk("i2_alu", 76'(alu_valid_out), 76'd1);
    handshake_alu();
    chk("i2_cnt", 76'(issued_count_out), 76'd2);

    // Memory issue with back-pressure
    i3 = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    send(i3);
    step();
    chk("i3_mem",   76'(mem_valid_out), 76'd1);
    chk("i3_alu",   76'(alu_valid_out), 76'd0);
    chk("i3_stall", 76'(stall_out),     76'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("i3_mem_hold",   76'(mem_valid_out), 76'd1);
      chk("i3_alu_hold",   76'(alu_valid_out), 76'd0);
      chk("i3_instr_hold", issue_instr_out,    i3);
    end
    mem_ready_in = 1'b1;
    #1;
    chk("i3_stall_rdy", 76'(stall_out), 76'd0);
    step();
    mem_ready_in = 1'b0;
    #1;
    chk("i3_cnt", 76'(issued_count_out), 76'd3);
    chk("i3_mem_done", 76'(mem_valid_out), 76'd0);

    // Stall-marked instruction is dropped
    i4 = mk(1'b0, 5'd0, 5'd0, 5'd5, 1'b1);
    send(i4);
    chk("i4_ready_hold", 76'(instr_ready_out), 76'd0);
    step();
    chk("i4_ready", 76'(instr_ready_out),  76'd1);
    chk("i4_alu",   76'(alu_valid_out),    76'd0);
    chk("i4_cnt",   76'(issued_count_out), 76'd3);

    // Flush coincident with ALU handshake
    i5 = mk(1'b0, 5'd0, 5'd0, 5'd6, 1'b0);
    send(i5);
    step();
    chk("i5_alu", 76'(alu_valid_out), 76'd1);
    alu_ready_in = 1'b1; flush_in = 1'b1;
    step();
    alu_ready_in = 1'b0; flush_in = 1'b0;
    #1;
    chk("flush_ready", 76'(instr_ready_out),  76'd1);
    chk("flush_alu",   76'(alu_valid_out),    76'd0);
    chk("flush_cnt",   76'(issued_count_out), 76'd3);
    chk("flush_instr", issue_instr_out,       76'd0);
    i6 = mk(1'b0, 5'd6, 5'd0, 5'd0, 1'b0);
    send(i6);
    chk("i6_nobusy", 76'(stall_out), 76'd0);
    step();
    chk("i6_alu", 76'(alu_valid_out), 76'd1);
    handshake_alu();
    chk("i6_cnt", 76'(issued_count_out), 76'd4);

    // Issue set and writeback clear of register 7 in the same cycle
    i8 = mk(1'b0, 5'd0, 5'd0, 5'd7, 1'b0);
    send(i8);
    step();
    alu_ready_in = 1'b1; wb_valid_in = 1'b1; wb_dest_in = 5'd7;
    step();
    alu_ready_in = 1'b0; wb_valid_in = 1'b0; wb_dest_in = '0;
    #1;
    chk("i8_cnt", 76'(issued_count_out), 76'd5);
    i9 = mk(1'b0, 5'd7, 5'd0, 5'd0, 1'b0);
    send(i9);
`ifdef DISPATCH_SCOREBOARD_EN
    chk("setwins_stall", 76'(stall_out), 76'd1);
`else
    chk("setwins_nosb", 76'(stall_out), 76'd0);
`endif
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    #1;
    chk("i9_flush_ready", 76'(instr_ready_out),  76'd1);
    chk("i9_flush_cnt",   76'(issued_count_out), 76'd5);

    // Counter saturation
    exp_cnt = 5;
    for (int k = 0; k < 12; k++) begin
      send(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0));
      step();
      handshake_alu();
      exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
      chk("sat_cnt", 76'(issued_count_out), 76'(exp_cnt));
    end

    // Reset in the middle of an issue handshake
    send(mk(1'b0, 5'd0, 5'd0, 5'd9, 1'b0));
    step();
    chk("pre_rst_alu", 76'(alu_valid_out), 76'd1);
    alu_ready_in = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 76'(instr_ready_out),  76'd1);
    chk("mid_rst_alu",   76'(alu_valid_out),    76'd0);
    chk("mid_rst_mem",   76'(mem_valid_out),    76'd0);
    chk("mid_rst_stall", 76'(stall_out),        76'd0);
    chk("mid_rst_instr", issue_instr_out,       76'd0);
    chk("mid_rst_cnt",   76'(issued_count_out), 76'd0);
    alu_ready_in = 1'b0;
    #2;
    rst_n = 1'b1;
    send(mk(1'b0, 5'd9, 5'd0, 5'd0, 1'b0));
    chk("post_rst_nobusy", 76'(stall_out), 76'd0);
    step();
    chk("post_rst_alu", 76'(alu_valid_out), 76'd1);
    handshake_alu();
    chk("post_rst_cnt", 76'(issued_count_out), 76'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
